taxi_axil_reg_bank: RTL and testbench

TAXI_AXIL_REG_BANK -- requirements
Module: taxi_axil_reg_bank

---
 rtl/taxi_axil_reg_bank_if.sv | 44 ++++
 rtl/taxi_axil_reg_bank.sv | 178 +++++++++++++++++
 tb/tb_taxi_axil_reg_bank.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axil_reg_bank_if.sv
// taxi_axil_if: AXI4-Lite bundle with separate write/read modports.
// Slave modports are used by the register bank; master ones by drivers.
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
  modport rd_slv (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport rd_mst (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/taxi_axil_reg_bank.sv
// taxi_axil_reg_bank: AXI4-Lite bank of REG_COUNT RW control registers
// followed by REG_COUNT RO status words; independent write/read FSMs.
module taxi_axil_reg_bank #(
  parameter int REG_COUNT = 16,
  parameter int DATA_W = 32,
  parameter logic [REG_COUNT*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  taxi_axil_if.wr_slv                 s_axil_wr,
  taxi_axil_if.rd_slv                 s_axil_rd,
  output logic [REG_COUNT*DATA_W-1:0] reg_out,
  output logic [REG_COUNT-1:0]        wr_pulse,
  input  logic [REG_COUNT*DATA_W-1:0] sts_in
);
  localparam int IF_DW = s_axil_wr.DATA_W;
  localparam int AW = s_axil_wr.ADDR_W;
  localparam int SW = s_axil_wr.STRB_W;
  localparam int AL = $clog2(SW);
  localparam int IW = AW - AL;
  localparam int RW = REG_COUNT * DATA_W;

  if (IF_DW != 8 * SW || IF_DW != DATA_W) begin : g_chk_w
    $fatal(1, "taxi_axil_reg_bank: data/strobe width mismatch");
  end
  if (IW < 31 && 2 * REG_COUNT > (1 << IW)) begin : g_chk_a
    $fatal(1, "taxi_axil_reg_bank: map exceeds address space");
  end

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t           wst_q, wst_d;
  rstate_t           rs_q, rs_d;
  logic              en_q;
  logic              aw_lat_q, aw_lat_d;
  logic              w_lat_q, w_lat_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [RW-1:0]     reg_q, reg_d;
  logic [REG_COUNT-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [IW-1:0]     ridx;
  logic              aw_hs, w_hs, ar_hs;
  logic              unused_ok;

  // readies are held low until the first edge after reset release
  assign s_axil_wr.awready = en_q && wst_q == W_COLLECT && !aw_lat_q;
  assign s_axil_wr.wready  = en_q && wst_q == W_COLLECT && !w_lat_q;
  assign s_axil_wr.bvalid  = wst_q == W_RESP;
  assign s_axil_wr.bresp   = bresp_q;
  assign s_axil_rd.arready = en_q && rs_q == R_IDLE;
  assign s_axil_rd.rvalid  = rs_q == R_DATA;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.rresp   = rresp_q;
  assign reg_out  = reg_q;
  assign wr_pulse = pulse_q;

  assign aw_hs = s_axil_wr.awvalid && s_axil_wr.awready;
  assign w_hs  = s_axil_wr.wvalid && s_axil_wr.wready;
  assign ar_hs = s_axil_rd.arvalid && s_axil_rd.arready;
  assign ridx  = s_axil_rd.araddr[AW-1:AL];
  assign unused_ok = ^{s_axil_wr.awprot, s_axil_rd.arprot,
                       s_axil_wr.awaddr, s_axil_rd.araddr};

  always_comb begin
    wst_d    = wst_q;
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    reg_d    = reg_q;
    pulse_d  = '0;
    unique case (wst_q)
      W_COLLECT: begin
        if (aw_lat_q && w_lat_q) begin
          wst_d   = W_RESP;
          bresp_d = 2'b10;
          for (int i = 0; i < REG_COUNT; i++) begin
            if (widx_q == IW'(i)) begin
              bresp_d    = 2'b00;
              pulse_d[i] = 1'b1;
              for (int b = 0; b < SW; b++) begin
                if (wstrb_q[b])
                  reg_d[i*DATA_W+b*8 +: 8] = wdata_q[b*8 +: 8];
              end
            end
          end
        end else begin
          if (aw_hs) begin
            aw_lat_d = 1'b1;
            widx_d   = s_axil_wr.awaddr[AW-1:AL];
          end
          if (w_hs) begin
            w_lat_d = 1'b1;
            wdata_d = s_axil_wr.wdata;
            wstrb_d = s_axil_wr.wstrb;
          end
        end
      end
      W_RESP: begin
        if (s_axil_wr.bready) begin
          wst_d    = W_COLLECT;
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
        end
      end
      default: wst_d = W_COLLECT;
    endcase
  end

  // reads sample reg_q before this edge's write lands
  always_comb begin
    rs_d    = rs_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rs_q)
      R_IDLE: begin
        if (ar_hs) begin
          rs_d    = R_DATA;
          rdata_d = '0;
          rresp_d = 2'b10;
          for (int i = 0; i < REG_COUNT; i++) begin
            if (ridx == IW'(i)) begin
              rdata_d = reg_q[i*DATA_W +: DATA_W];
              rresp_d = 2'b00;
            end
            if (ridx == IW'(REG_COUNT + i)) begin
              rdata_d = sts_in[i*DATA_W +: DATA_W];
              rresp_d = 2'b00;
            end
          end
        end
      end
      R_DATA: begin
        if (s_axil_rd.rready) rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      wst_q    <= W_COLLECT;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
      reg_q    <= RESET_VAL;
      pulse_q  <= '0;
      rs_q     <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      en_q     <= 1'b1;
      wst_q    <= wst_d;
      aw_lat_q <= aw_lat_d;
      w_lat_q  <= w_lat_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      reg_q    <= reg_d;
      pulse_q  <= pulse_d;
      rs_q     <= rs_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end
endmodule

// File: tb/tb_taxi_axil_reg_bank.sv
// tb_taxi_axil_reg_bank: directed table plus hand sequences for
// latency, back-pressure, same-cycle read/write and mid-transaction reset.
module tb_taxi_axil_reg_bank;
  localparam int RC = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  taxi_axil_if #(.DATA_W(DW), .ADDR_W(8)) axil ();

  logic [RC*DW-1:0] reg_out;
  logic [RC*DW-1:0] sts_in;
  logic [RC-1:0]    wr_pulse;

  localparam logic [RC*DW-1:0] STS =
    {32'h0BAD0003, 32'h0BAD0002, 32'hCAFE0001, 32'h0BAD0000};
  assign sts_in = STS;

  taxi_axil_reg_bank #(
    .REG_COUNT(RC),
    .DATA_W(DW),
    .RESET_VAL('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axil_wr(axil),
    .s_axil_rd(axil),
    .reg_out(reg_out),
    .wr_pulse(wr_pulse),
    .sts_in(sts_in)
  );

  int total = 0;
  int bad = 0;
  logic [RC-1:0] pulse_seen = '0;
  logic [RC-1:0] prev_pulse = '0;
  int pulse_long = 0;
  logic [31:0] mdl [RC];

  always @(negedge clk) begin
    if (wr_pulse != 0 && prev_pulse != 0) pulse_long++;
    prev_pulse = wr_pulse;
    pulse_seen = pulse_seen | wr_pulse;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [RC*DW-1:0] mdl_flat();
    logic [RC*DW-1:0] f;
    for (int i = 0; i < RC; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output bit ok);
    bit got = 0;
    bit aw_hs, w_hs, b_hs;
    resp = 2'bxx;
    axil.awaddr = a; axil.awvalid = 1'b1;
    axil.wdata = d; axil.wstrb = s; axil.wvalid = 1'b1;
    axil.bready = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      aw_hs = axil.awvalid && axil.awready;
      w_hs  = axil.wvalid && axil.wready;
      b_hs  = axil.bvalid && axil.bready;
      if (b_hs) resp = axil.bresp;
      @(posedge clk); #1;
      if (aw_hs) axil.awvalid = 1'b0;
      if (w_hs) axil.wvalid = 1'b0;
      if (b_hs) got = 1;
    end
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.bready = 1'b0;
    ok = got;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output bit ok);
    bit got = 0;
    bit ar_hs, r_hs;
    d = 'x; resp = 2'bxx;
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      ar_hs = axil.arvalid && axil.arready;
      r_hs  = axil.rvalid && axil.rready;
      if (r_hs) begin d = axil.rdata; resp = axil.rresp; end
      @(posedge clk); #1;
      if (ar_hs) axil.arvalid = 1'b0;
      if (r_hs) got = 1;
    end
    axil.arvalid = 1'b0; axil.rready = 1'b0;
    ok = got;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  vec_t v[15];

  initial begin
    logic [1:0] resp;
    logic [31:0] rd;
    bit ok;
    int idx;
    int bseen;
    logic [RC-1:0] exp_pulse;

    v[0]  = '{1, 8'h00, 32'h12345678, 4'hF, 32'h0, 2'b00};
    v[1]  = '{0, 8'h00, 32'h0, 4'h0, 32'h12345678, 2'b00};
    v[2]  = '{1, 8'h08, 32'h11223344, 4'hF, 32'h0, 2'b00};
    v[3]  = '{1, 8'h08, 32'hAABBCCDD, 4'h5, 32'h0, 2'b00};
    v[4]  = '{0, 8'h08, 32'h0, 4'h0, 32'h11BB33DD, 2'b00};
    v[5]  = '{0, 8'h14, 32'h0, 4'h0, 32'hCAFE0001, 2'b00};
    v[6]  = '{1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10};
    v[7]  = '{0, 8'h20, 32'h0, 4'h0, 32'h00000000, 2'b10};
    v[8]  = '{1, 8'h3C, 32'h12121212, 4'hF, 32'h0, 2'b10};
    v[9]  = '{0, 8'h10, 32'h0, 4'h0, 32'h0BAD0000, 2'b00};
    v[10] = '{1, 8'h0C, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00};
    v[11] = '{0, 8'h0F, 32'h0, 4'h0, 32'h00000000, 2'b00};
    v[12] = '{0, 8'h1C, 32'h0, 4'h0, 32'h0BAD0003, 2'b00};
    v[13] = '{1, 8'h0E, 32'h000000A5, 4'h1, 32'h0, 2'b00};
    v[14] = '{0, 8'h0C, 32'h0, 4'h0, 32'h000000A5, 2'b00};

    for (int i = 0; i < RC; i++) mdl[i] = '0;
    axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
    axil.bready = 1'b0; axil.araddr = '0; axil.arprot = '0;
    axil.arvalid = 1'b0; axil.rready = 1'b0;

    // reset state
    #2;
    chk("rst_hs", {axil.awready, axil.wready, axil.arready,
                   axil.bvalid, axil.rvalid}, 5'b0);
    chk("rst_pay", {axil.bresp, axil.rresp, axil.rdata, wr_pulse}, '0);
    chk("rst_reg", reg_out, '0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", {axil.awready, axil.wready, axil.arready}, 3'b000);
    @(posedge clk); #1;
    chk("rdy_first_edge", {axil.awready, axil.wready, axil.arready}, 3'b111);

    // AW alone, W three cycles later
    pulse_seen = '0;
    axil.awaddr = 8'h04; axil.awvalid = 1'b1;
    @(negedge clk);
    chk("aw_rdy", axil.awready, 1'b1);
    @(posedge clk); #1;
    axil.awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("aw_wait", {axil.awready, axil.wready, axil.bvalid, wr_pulse,
                      reg_out}, {3'b010, 4'b0, mdl_flat()});
      @(posedge clk); #1;
    end
    axil.wdata = 32'hDEADBEEF; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
    axil.bready = 1'b1;
    @(negedge clk);
    chk("w_rdy", axil.wready, 1'b1);
    @(posedge clk); #1;
    axil.wvalid = 1'b0;
    @(negedge clk);
    chk("w_perform", {axil.bvalid, wr_pulse, reg_out},
        {1'b0, 4'b0, mdl_flat()});
    @(posedge clk); #1;
    mdl[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("w_resp", {axil.bvalid, axil.bresp, wr_pulse, reg_out},
        {1'b1, 2'b00, 4'b0010, mdl_flat()});
    @(posedge clk); #1;
    axil.bready = 1'b0;
    @(negedge clk);
    chk("w_after", {axil.bvalid, axil.awready, axil.wready, wr_pulse},
        {3'b011, 4'b0});
    @(posedge clk); #1;

    // table
    for (int i = 0; i < 15; i++) begin
      pulse_seen = '0;
      idx = int'(v[i].addr[7:2]);
      if (v[i].wr) begin
        do_write(v[i].addr, v[i].data, v[i].strb, resp, ok);
        chk($sformatf("v%0d_done", i), ok, 1'b1);
        chk($sformatf("v%0d_bresp", i), resp, v[i].resp);
        exp_pulse = '0;
        if (idx < RC) begin
          exp_pulse[idx] = 1'b1;
          for (int b = 0; b < 4; b++)
            if (v[i].strb[b]) mdl[idx][b*8 +: 8] = v[i].data[b*8 +: 8];
        end
        chk($sformatf("v%0d_pulse", i), pulse_seen, exp_pulse);
        chk($sformatf("v%0d_reg", i), reg_out, mdl_flat());
      end else begin
        do_read(v[i].addr, rd, resp, ok);
        chk($sformatf("v%0d_done", i), ok, 1'b1);
        chk($sformatf("v%0d_rdata", i), rd, v[i].exp);
        chk($sformatf("v%0d_rresp", i), resp, v[i].resp);
        chk($sformatf("v%0d_pulse", i), pulse_seen, 4'b0);
      end
    end

    // write and read together under back-pressure
    axil.awaddr = 8'h0C; axil.wdata = 32'h55AA55AA; axil.wstrb = 4'hF;
    axil.araddr = 8'h04;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.arvalid = 1'b1;
    @(negedge clk);
    chk("bp_accept", {axil.awready, axil.wready, axil.arready}, 3'b111);
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold", {axil.bvalid, axil.bresp, axil.rvalid, axil.rdata,
                      axil.rresp, axil.awready, axil.wready, axil.arready},
          {1'b1, 2'b00, 1'b1, 32'hDEADBEEF, 2'b00, 3'b000});
      @(posedge clk); #1;
    end
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(posedge clk); #1;
    axil.bready = 1'b0; axil.rready = 1'b0;
    mdl[3] = 32'h55AA55AA;
    @(negedge clk);
    chk("bp_release", {axil.bvalid, axil.rvalid, axil.awready,
                       axil.wready, axil.arready}, 5'b00111);
    chk("bp_reg", reg_out, mdl_flat());
    @(posedge clk); #1;

    // read accepted on the write-update edge sees the old value
    axil.awaddr = 8'h00; axil.wdata = 32'h0BADF00D; axil.wstrb = 4'hF;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    axil.araddr = 8'h00; axil.arvalid = 1'b1;
    @(negedge clk);
    chk("rw_ar_rdy", axil.arready, 1'b1);
    @(posedge clk); #1;
    axil.arvalid = 1'b0;
    @(negedge clk);
    chk("rw_old", {axil.rvalid, axil.rdata, axil.bvalid},
        {1'b1, mdl[0], 1'b1});
    mdl[0] = 32'h0BADF00D;
    chk("rw_reg", reg_out, mdl_flat());
    @(posedge clk); #1;
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(posedge clk); #1;
    axil.bready = 1'b0; axil.rready = 1'b0;

    // reset between AW and W
    axil.awaddr = 8'h04; axil.awvalid = 1'b1;
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.bready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_hs", {axil.awready, axil.wready, axil.arready,
                  axil.bvalid, axil.rvalid}, 5'b0);
    chk("mr_reg", {reg_out, wr_pulse}, '0);
    for (int i = 0; i < RC; i++) mdl[i] = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_rdy", {axil.awready, axil.wready, axil.arready}, 3'b111);
    bseen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (axil.bvalid) bseen++;
      @(posedge clk); #1;
    end
    axil.bready = 1'b0;
    chk("mr_no_b", bseen, 0);
    chk("mr_reg_end", reg_out, mdl_flat());
    chk("pulse_width", pulse_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
